// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the hazard/stall controller.
package hazard_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 16;

  // Load in EX writing a register that the instruction in ID reads.
  // Register 0 never creates a dependency.
  function automatic logic load_use_hit(
    input logic       idex_mem_read,
    input logic [4:0] idex_rt,
    input logic [4:0] ifid_rs,
    input logic [4:0] ifid_rt
  );
    return idex_mem_read && (idex_rt != 5'd0) &&
           ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear wins, otherwise count up and stop at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard / memory-stall controller.
//   state    | meaning
//   RUN      | normal flow; load-use stall and branch flush decoded here
//   MEM_WAIT | data memory access outstanding, pipeline frozen until ack
//   ERROR    | memory never answered; pipeline frozen until reset
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegisterRt_i,
  input  logic [4:0]       IFID_RegisterRs_i,
  input  logic [4:0]       IFID_RegisterRt_i,
  input  logic             Branch_Taken_i,
  input  logic             EXMEM_MemAccess_i,
  input  logic             DMem_Ack_i,
  input  logic             Cnt_Clr_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Pipe_Freeze_o,
  output logic             DMem_Req_o,
  output logic             Mem_Err_o,
  output logic [CNT_W-1:0] Stall_Cnt_o
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state_d, state_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic              mem_err_d, mem_err_q;
  logic              freeze;
  logic              load_use;

  assign load_use = load_use_hit(IDEX_MemRead_i, IDEX_RegisterRt_i,
                                 IFID_RegisterRs_i, IFID_RegisterRt_i);

  // FSM next state, watchdog and memory-side outputs
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    mem_err_d  = mem_err_q;
    freeze     = 1'b0;
    DMem_Req_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        DMem_Req_o = EXMEM_MemAccess_i;
        if (EXMEM_MemAccess_i && !DMem_Ack_i) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        DMem_Req_o = 1'b1;
        if (DMem_Ack_i) begin
          state_d = ST_RUN;
        end else begin
          freeze = 1'b1;
          if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d   = ST_ERROR;
            mem_err_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ST_ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Pipeline enables: freeze beats load-use, load-use beats branch flush
  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IDEX_Bubble_o = 1'b0;
    IFID_Flush_o  = 1'b0;
    if (freeze) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (load_use) begin
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end else if (Branch_Taken_i) begin
        IFID_Flush_o = 1'b1;
      end
    end
  end

  // State, watchdog and sticky error registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign Pipe_Freeze_o = freeze;
  assign Mem_Err_o     = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~PCWrite_o),
    .clr_i (Cnt_Clr_i),
    .cnt_o (Stall_Cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (TIMEOUT=4, CNT_W=4).
module tb_hazard_stall_controller;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_RegisterRt_i;
  logic [4:0] IFID_RegisterRs_i;
  logic [4:0] IFID_RegisterRt_i;
  logic       Branch_Taken_i;
  logic       EXMEM_MemAccess_i;
  logic       DMem_Ack_i;
  logic       Cnt_Clr_i;
  logic       PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o;
  logic       Pipe_Freeze_o, DMem_Req_o, Mem_Err_o;
  logic [3:0] Stall_Cnt_o;

  // {PCWrite, IFID_Write, Bubble, Flush, Freeze, Req, Err}
  logic [6:0] ctl;
  assign ctl = {PCWrite_o, IFID_Write_o, IDEX_Bubble_o, IFID_Flush_o,
                Pipe_Freeze_o, DMem_Req_o, Mem_Err_o};

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  hazard_stall_controller #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .IDEX_MemRead_i    (IDEX_MemRead_i),
    .IDEX_RegisterRt_i (IDEX_RegisterRt_i),
    .IFID_RegisterRs_i (IFID_RegisterRs_i),
    .IFID_RegisterRt_i (IFID_RegisterRt_i),
    .Branch_Taken_i    (Branch_Taken_i),
    .EXMEM_MemAccess_i (EXMEM_MemAccess_i),
    .DMem_Ack_i        (DMem_Ack_i),
    .Cnt_Clr_i         (Cnt_Clr_i),
    .PCWrite_o         (PCWrite_o),
    .IFID_Write_o      (IFID_Write_o),
    .IFID_Flush_o      (IFID_Flush_o),
    .IDEX_Bubble_o     (IDEX_Bubble_o),
    .Pipe_Freeze_o     (Pipe_Freeze_o),
    .DMem_Req_o        (DMem_Req_o),
    .Mem_Err_o         (Mem_Err_o),
    .Stall_Cnt_o       (Stall_Cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    IDEX_MemRead_i    = 1'b0;
    IDEX_RegisterRt_i = 5'd0;
    IFID_RegisterRs_i = 5'd0;
    IFID_RegisterRt_i = 5'd0;
    Branch_Taken_i    = 1'b0;
    EXMEM_MemAccess_i = 1'b0;
    DMem_Ack_i        = 1'b0;
    Cnt_Clr_i         = 1'b0;
  endtask

  task automatic clear_cnt();
    Cnt_Clr_i = 1'b1;
    tick();
    Cnt_Clr_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    #3;
    checks++;
    if (ctl !== 7'b1100000) begin
      errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b1100000);
    end
    checks++;
    if (Stall_Cnt_o !== 4'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", Stall_Cnt_o);
    end
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    clear_cnt();
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd5; IFID_RegisterRs_i = 5'd5;
    #2;
    checks++;
    if (ctl !== 7'b0010000) begin
      errors++; $display("FAIL load_use_rs got=%b exp=%b", ctl, 7'b0010000);
    end
    tick();
    idle();
    #2;
    checks++;
    if (ctl !== 7'b1100000 || Stall_Cnt_o !== 4'd1) begin
      errors++; $display("FAIL load_use_after ctl=%b cnt=%0d exp ctl=1100000 cnt=1", ctl, Stall_Cnt_o);
    end
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd9;
    IFID_RegisterRs_i = 5'd3; IFID_RegisterRt_i = 5'd9;
    #2;
    checks++;
    if (ctl !== 7'b0010000) begin
      errors++; $display("FAIL load_use_rt got=%b exp=%b", ctl, 7'b0010000);
    end
    tick();
    idle();
    #2;
    checks++;
    if (Stall_Cnt_o !== 4'd2) begin
      errors++; $display("FAIL load_use_cnt got=%0d exp=2", Stall_Cnt_o);
    end
  endtask

  task automatic test_no_hazard();
    clear_cnt();
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd0;
    IFID_RegisterRs_i = 5'd0; IFID_RegisterRt_i = 5'd0;
    #2;
    checks++;
    if (ctl !== 7'b1100000) begin
      errors++; $display("FAIL rt_zero got=%b exp=%b", ctl, 7'b1100000);
    end
    tick();
    IDEX_MemRead_i = 1'b0; IDEX_RegisterRt_i = 5'd5; IFID_RegisterRs_i = 5'd5;
    #2;
    checks++;
    if (ctl !== 7'b1100000) begin
      errors++; $display("FAIL no_memread got=%b exp=%b", ctl, 7'b1100000);
    end
    tick();
    idle();
    #2;
    checks++;
    if (Stall_Cnt_o !== 4'd0) begin
      errors++; $display("FAIL no_hazard_cnt got=%0d exp=0", Stall_Cnt_o);
    end
  endtask

  task automatic test_branch();
    clear_cnt();
    Branch_Taken_i = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b1101000) begin
      errors++; $display("FAIL branch_flush got=%b exp=%b", ctl, 7'b1101000);
    end
    tick();
    Branch_Taken_i = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b1100000 || Stall_Cnt_o !== 4'd0) begin
      errors++; $display("FAIL branch_after ctl=%b cnt=%0d exp ctl=1100000 cnt=0", ctl, Stall_Cnt_o);
    end
  endtask

  task automatic test_priority();
    clear_cnt();
    Branch_Taken_i = 1'b1;
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd7; IFID_RegisterRt_i = 5'd7;
    #2;
    checks++;
    if (ctl !== 7'b0010000) begin
      errors++; $display("FAIL lu_beats_branch got=%b exp=%b", ctl, 7'b0010000);
    end
    tick();
    IDEX_MemRead_i = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b1101000) begin
      errors++; $display("FAIL branch_reeval got=%b exp=%b", ctl, 7'b1101000);
    end
    tick();
    idle();
    #2;
    checks++;
    if (Stall_Cnt_o !== 4'd1) begin
      errors++; $display("FAIL priority_cnt got=%0d exp=1", Stall_Cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    clear_cnt();
    EXMEM_MemAccess_i = 1'b1; DMem_Ack_i = 1'b0;
    Branch_Taken_i = 1'b1;
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd4; IFID_RegisterRs_i = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (ctl !== 7'b0000110) begin
        errors++; $display("FAIL freeze_cycle%0d got=%b exp=%b", i, ctl, 7'b0000110);
      end
      tick();
    end
    DMem_Ack_i = 1'b1; Branch_Taken_i = 1'b0; IDEX_MemRead_i = 1'b0;
    #2;
    checks++;
    if (PCWrite_o !== 1'b1 || Pipe_Freeze_o !== 1'b0) begin
      errors++; $display("FAIL ack_cycle pcwrite=%b freeze=%b exp pcwrite=1 freeze=0", PCWrite_o, Pipe_Freeze_o);
    end
    tick();
    idle();
    #2;
    checks++;
    if (ctl !== 7'b1100000 || Stall_Cnt_o !== 4'd3) begin
      errors++; $display("FAIL back_to_run ctl=%b cnt=%0d exp ctl=1100000 cnt=3", ctl, Stall_Cnt_o);
    end
    EXMEM_MemAccess_i = 1'b1; DMem_Ack_i = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b1100010) begin
      errors++; $display("FAIL run_hit got=%b exp=%b", ctl, 7'b1100010);
    end
    tick();
    idle();
    #2;
    checks++;
    if (ctl !== 7'b1100000 || Stall_Cnt_o !== 4'd3) begin
      errors++; $display("FAIL run_hit_after ctl=%b cnt=%0d exp ctl=1100000 cnt=3", ctl, Stall_Cnt_o);
    end
  endtask

  task automatic test_reset_abort();
    EXMEM_MemAccess_i = 1'b1; DMem_Ack_i = 1'b0;
    tick();
    #1;
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    EXMEM_MemAccess_i = 1'b0;
    #1;
    checks++;
    if (ctl !== 7'b1100000 || Stall_Cnt_o !== 4'd0) begin
      errors++; $display("FAIL reset_abort ctl=%b cnt=%0d exp ctl=1100000 cnt=0", ctl, Stall_Cnt_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    clear_cnt();
    EXMEM_MemAccess_i = 1'b1; DMem_Ack_i = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b0000110) begin
      errors++; $display("FAIL to_run_freeze got=%b exp=%b", ctl, 7'b0000110);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      #2;
      checks++;
      if (ctl !== 7'b0000110) begin
        errors++; $display("FAIL to_wait%0d got=%b exp=%b", i, ctl, 7'b0000110);
      end
    end
    tick();
    EXMEM_MemAccess_i = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b0000101 || Stall_Cnt_o !== 4'd5) begin
      errors++; $display("FAIL to_error ctl=%b cnt=%0d exp ctl=0000101 cnt=5", ctl, Stall_Cnt_o);
    end
    for (int i = 0; i < 12; i++) tick();
    #2;
    checks++;
    if (ctl !== 7'b0000101 || Stall_Cnt_o !== 4'd15) begin
      errors++; $display("FAIL error_sat ctl=%b cnt=%0d exp ctl=0000101 cnt=15", ctl, Stall_Cnt_o);
    end
    Cnt_Clr_i = 1'b1;
    tick();
    Cnt_Clr_i = 1'b0;
    #2;
    checks++;
    if (Stall_Cnt_o !== 4'd0) begin
      errors++; $display("FAIL clr_beats_inc got=%0d exp=0", Stall_Cnt_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (ctl !== 7'b1100000 || Stall_Cnt_o !== 4'd0) begin
      errors++; $display("FAIL error_reset ctl=%b cnt=%0d exp ctl=1100000 cnt=0", ctl, Stall_Cnt_o);
    end
    rst_i = 1'b1;
    tick();
    EXMEM_MemAccess_i = 1'b1; DMem_Ack_i = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b1100010) begin
      errors++; $display("FAIL post_reset_run got=%b exp=%b", ctl, 7'b1100010);
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_priority();
    test_mem_wait();
    test_reset_abort();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent in MEM_WAIT before entering ERROR.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of Stall_Cnt_o.
REQ-003 Ports SHALL be exactly as listed below. The block has one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- IDEX_MemRead_i  in  1  load in EX.
- IDEX_RegisterRt_i  in  5  load destination.
- IFID_RegisterRs_i  in  5  ID source.
- IFID_RegisterRt_i  in  5  ID source.
- Branch_Taken_i  in  1  branch resolved taken in ID.
- EXMEM_MemAccess_i  in  1  MemRead or MemWrite in MEM.
- DMem_Ack_i  in  1  data memory completes this cycle.
- Cnt_Clr_i  in  1  synchronous counter clear.
- PCWrite_o  out  1  PC enable.
- IFID_Write_o  out  1  IF/ID enable.
- IFID_Flush_o  out  1  zero IF/ID.
- IDEX_Bubble_o  out  1  insert NOP into ID/EX.
- Pipe_Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- DMem_Req_o  out  1  memory request.
- Mem_Err_o  out  1  sticky timeout flag.
- Stall_Cnt_o  out  CNT_W  stall-cycle count.

Function
REQ-004 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR.
REQ-005 In RUN, EXMEM_MemAccess_i=1 with DMem_Ack_i=0 SHALL:
- assert Pipe_Freeze_o in that same cycle (Mealy);
- move to MEM_WAIT on the next edge.
REQ-006 In RUN, EXMEM_MemAccess_i=1 with DMem_Ack_i=1 SHALL stay in RUN with no freeze.
REQ-007 In MEM_WAIT, Pipe_Freeze_o and DMem_Req_o SHALL be 1 while DMem_Ack_i=0.
REQ-008 In MEM_WAIT, DMem_Ack_i=1 SHALL deassert Pipe_Freeze_o in that cycle and return to RUN on the next edge.
REQ-009 The wait counter SHALL:
- clear on entry to MEM_WAIT;
- increment each MEM_WAIT cycle without ack;
- on reaching TIMEOUT-1 without ack, move the FSM to ERROR.
REQ-010 ERROR SHALL be terminal until reset, with:
- Mem_Err_o=1 and Pipe_Freeze_o=1;
- PCWrite_o=0 and IFID_Write_o=0;
- DMem_Req_o=0.
REQ-011 DMem_Req_o SHALL equal EXMEM_MemAccess_i in RUN.
REQ-012 A load-use hazard SHALL be defined as IDEX_MemRead_i=1 with IDEX_RegisterRt_i!=0 and equal to IFID_RegisterRs_i or IFID_RegisterRt_i.
REQ-013 A load-use hazard in RUN with no freeze SHALL force PCWrite_o=0, IFID_Write_o=0 and IDEX_Bubble_o=1 for that cycle only.
REQ-014 Branch_Taken_i in RUN with no freeze and no load-use SHALL set IFID_Flush_o=1 for one cycle; PCWrite_o stays 1.
REQ-015 When a load-use hazard and a taken branch occur together, load-use SHALL win: IFID_Flush_o=0, and the branch re-evaluates next cycle.
REQ-016 Whenever Pipe_Freeze_o=1, the block SHALL drive:
- PCWrite_o=0 and IFID_Write_o=0;
- IDEX_Bubble_o=0 and IFID_Flush_o=0.
- Freeze SHALL override load-use and branch.
REQ-017 Otherwise PCWrite_o=1, IFID_Write_o=1, IDEX_Bubble_o=0 and IFID_Flush_o=0.
REQ-018 Stall_Cnt_o SHALL:
- increment on every edge with PCWrite_o=0;
- saturate at all-ones;
- with Cnt_Clr_i=1, load 0 on that edge; clear SHALL beat increment.

Reset
REQ-019 rst_i=0 SHALL asynchronously set:
- FSM=RUN;
- wait counter=0, Stall_Cnt_o=0, Mem_Err_o=0.
REQ-020 Reset asserted in MEM_WAIT or ERROR SHALL abort the access; after release, outputs follow REQ-011 to REQ-017 from RUN.

Structure
REQ-021 Package hazard_pkg SHALL hold the state encoding (RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10) and the default TIMEOUT and CNT_W values.
REQ-022 Sub-module sat_counter (CNT_W wide, inc and clr inputs) SHALL implement Stall_Cnt_o; the FSM, watchdog and hazard decode SHALL stay in the top module.

Verification
REQ-023 IDEX_MemRead_i=1, IDEX_RegisterRt_i=5, IFID_RegisterRs_i=5 -> one cycle with PCWrite_o=0, IDEX_Bubble_o=1; Stall_Cnt_o=1.
REQ-024 Same hazard with IDEX_RegisterRt_i=0 -> no stall.
REQ-025 EXMEM_MemAccess_i=1, DMem_Ack_i low for 3 cycles then high -> Pipe_Freeze_o=1 for 3 cycles, 0 in the ack cycle, FSM back to RUN; Stall_Cnt_o=3.
REQ-026 Load-use and Branch_Taken_i asserted together -> IDEX_Bubble_o=1, IFID_Flush_o=0.
REQ-027 Branch_Taken_i alone -> IFID_Flush_o=1 for exactly one cycle.
REQ-028 TIMEOUT=4 with no ack -> ERROR after 4 MEM_WAIT cycles, Mem_Err_o=1, DMem_Req_o=0; rst_i pulse mid-ERROR -> Mem_Err_o=0, RUN; counter saturation at CNT_W=4 holds 15.
